// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_queue slice: read-mode constants and width helpers.
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Occupancy counter width: must be able to hold the value DEPTH itself.
    function automatic int fifo_cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Pointer width; a single-entry FIFO still gets a 1-bit pointer held at 0.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer with increment enable and synchronous active-low clear.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = fifo_ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          i_clr_n,
    input  logic          i_inc,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;

    // Wrap is an explicit compare so non-power-of-two depths stay in range.
    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + PW'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_queue.sv
// Synchronous FIFO, arbitrary depth, registered-read or FWFT read mode.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow registers.
module fifo_queue
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  DEPTH      = 4,
    parameter int  FWFT       = FIFO_MODE_REG,
    parameter int  AF_THRESH  = DEPTH - 1,
    parameter int  AE_THRESH  = 1,
    localparam int CW         = fifo_cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = fifo_ptr_w(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         w_wr_ptr;
    logic [PW-1:0]         w_rd_ptr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_wr_acc = din_valid && !w_full;
    assign w_rd_acc = read_en && !w_empty;

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk     (clk),
        .i_clr_n (rst),
        .i_inc   (w_wr_acc),
        .o_ptr   (w_wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk     (clk),
        .i_clr_n (rst),
        .i_inc   (w_rd_acc),
        .o_ptr   (w_rd_ptr)
    );

    // Storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (rst && w_wr_acc) begin
            r_mem[w_wr_ptr] <= din;
        end
    end

    // Occupancy tracks accepted transfers only; a simultaneous pair cancels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign dout       = r_mem[w_rd_ptr];
            assign dout_valid = !w_empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_dout;
            logic                  r_dout_valid;

            // Registered read: dout holds between pops, valid is a one-cycle strobe.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else if (w_rd_acc) begin
                    r_dout       <= r_mem[w_rd_ptr];
                    r_dout_valid <= 1'b1;
                end else begin
                    r_dout       <= r_dout;
                    r_dout_valid <= 1'b0;
                end
            end

            assign dout       = r_dout;
            assign dout_valid = r_dout_valid;
        end
    endgenerate

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | (din_valid && w_full);
            r_underflow <= r_underflow | (read_en && w_empty);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_count >= CW'(AF_THRESH));
    assign almost_empty = (r_count <= CW'(AE_THRESH));
    assign count        = r_count;

endmodule
